// File: rtl/spi_flash_reader.sv
// Serial-flash READ sequencer that owns the SPI master register port and arbitrates CPU access.
// Optional macro SPI_FLASH_FASTREAD_EN selects FAST_READ (opcode 0Bh plus one dummy byte).
module spi_flash_reader #(
   parameter int         LEN_W    = 16,
   parameter logic [7:0] CMD_READ = 8'h03
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic [23:0]      addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [7:0]       byte_o,
   output logic             byte_valid_o,
   input  logic             byte_ready_i,
   input  logic [7:0]       cpu_d_i,
   input  logic             cpu_wr_i,
   input  logic             cpu_rd_i,
   input  logic             cpu_ad_i,
   output logic [7:0]       cpu_d_o,
   output logic             cpu_blocked_o,
   output logic [7:0]       spi_d_o,
   input  logic [7:0]       spi_d_i,
   output logic             spi_wr_o,
   output logic             spi_rd_o,
   output logic             spi_ad_o
);
   // state  | meaning
   // IDLE   | CPU owns the SPI port, waiting for start_i
   // SEL    | CONTROL write 01h (select flash)
   // TX     | DATA write of next header or 00h fill byte
   // POLL   | CONTROL read until BUSY clears
   // RDBYTE | DATA read, capture received byte
   // PUSH   | hold byte until consumer accepts it
   // DESEL  | CONTROL write 00h (deselect flash)
   // DONE   | one-cycle completion pulse
   typedef enum logic [2:0] {
      IDLE, SEL, TX, POLL, RDBYTE, PUSH, DESEL, DONE
   } state_t;

`ifdef SPI_FLASH_FASTREAD_EN
   localparam int               HDR_W    = 3;
   localparam logic [7:0]       OPCODE   = 8'h0B;
   localparam logic [HDR_W-1:0] HDR_LAST = 3'd4;
`else
   localparam int               HDR_W    = 2;
   localparam logic [7:0]       OPCODE   = CMD_READ;
   localparam logic [HDR_W-1:0] HDR_LAST = 2'd3;
`endif

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [23:0]        addr_q, addr_d;
   logic [HDR_W-1:0]   hdr_idx_q, hdr_idx_d;
   logic               in_hdr_q, in_hdr_d;
   logic               rx_q, rx_d;
   logic [7:0]         byte_q, byte_d;
   logic               byte_valid_q, byte_valid_d;
   logic               blocked_q, blocked_d;
   logic [7:0]         hdr_byte;
   logic               fsm_wr, fsm_rd, fsm_ad;
   logic [7:0]         fsm_dat;

   // Indices past the address (the FAST_READ dummy) fall through to 00h.
   always_comb begin
      hdr_byte = 8'h00;
      case (hdr_idx_q)
         HDR_W'(0): hdr_byte = OPCODE;
         HDR_W'(1): hdr_byte = addr_q[23:16];
         HDR_W'(2): hdr_byte = addr_q[15:8];
         HDR_W'(3): hdr_byte = addr_q[7:0];
         default:   hdr_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      hdr_idx_d    = hdr_idx_q;
      in_hdr_d     = in_hdr_q;
      rx_d         = rx_q;
      byte_d       = byte_q;
      byte_valid_d = byte_valid_q;
      fsm_wr       = 1'b0;
      fsm_rd       = 1'b0;
      fsm_ad       = 1'b0;
      fsm_dat      = 8'h00;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               addr_d    = addr_i;
               cnt_d     = len_i;
               hdr_idx_d = '0;
               in_hdr_d  = 1'b1;
               rx_d      = 1'b0;
               state_d   = (len_i == '0) ? DONE : SEL;
            end
         end
         SEL: begin
            fsm_wr  = 1'b1;
            fsm_dat = 8'h01;
            state_d = TX;
         end
         TX: begin
            fsm_wr = 1'b1;
            fsm_ad = 1'b1;
            if (in_hdr_q) begin
               fsm_dat   = hdr_byte;
               hdr_idx_d = hdr_idx_q + 1'b1;
               in_hdr_d  = (hdr_idx_q != HDR_LAST);
               rx_d      = 1'b0;
            end else begin
               rx_d = 1'b1;
            end
            state_d = POLL;
         end
         POLL: begin
            fsm_rd = 1'b1;
            if (!spi_d_i[7]) state_d = rx_q ? RDBYTE : TX;
         end
         RDBYTE: begin
            fsm_rd       = 1'b1;
            fsm_ad       = 1'b1;
            byte_d       = spi_d_i;
            byte_valid_d = 1'b1;
            state_d      = PUSH;
         end
         PUSH: begin
            if (byte_ready_i) begin
               byte_valid_d = 1'b0;
               cnt_d        = cnt_q - 1'b1;
               state_d      = (cnt_q == LEN_W'(1)) ? DESEL : TX;
            end
         end
         DESEL: begin
            fsm_wr  = 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q != IDLE) && (state_q != DONE);
   assign done_o = (state_q == DONE);

   always_comb begin
      blocked_d = blocked_q;
      if (busy_o && (cpu_wr_i || cpu_rd_i))
         blocked_d = 1'b1;
      else if (!busy_o && cpu_rd_i && !cpu_ad_i)
         blocked_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         hdr_idx_q    <= '0;
         in_hdr_q     <= 1'b0;
         rx_q         <= 1'b0;
         byte_q       <= 8'h00;
         byte_valid_q <= 1'b0;
         blocked_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         hdr_idx_q    <= hdr_idx_d;
         in_hdr_q     <= in_hdr_d;
         rx_q         <= rx_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         blocked_q    <= blocked_d;
      end
   end

   assign byte_o        = byte_q;
   assign byte_valid_o  = byte_valid_q;
   assign cpu_blocked_o = blocked_q;
   assign cpu_d_o       = busy_o ? 8'hFF : spi_d_i;
   assign spi_wr_o      = busy_o ? fsm_wr  : cpu_wr_i;
   assign spi_rd_o      = busy_o ? fsm_rd  : cpu_rd_i;
   assign spi_ad_o      = busy_o ? fsm_ad  : cpu_ad_i;
   assign spi_d_o       = busy_o ? fsm_dat : cpu_d_i;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a small SPI core model (3-cycle BUSY per exchange).
module tb_spi_flash_reader;
   logic        clk = 1'b0;
   logic        resetn;
   logic        start_i;
   logic [23:0] addr_i;
   logic [15:0] len_i;
   logic        busy_o, done_o, byte_valid_o, byte_ready_i;
   logic [7:0]  byte_o;
   logic [7:0]  cpu_d_i, cpu_d_o;
   logic        cpu_wr_i, cpu_rd_i, cpu_ad_i, cpu_blocked_o;
   logic [7:0]  spi_d_o, spi_d_i;
   logic        spi_wr_o, spi_rd_o, spi_ad_o;

   int checks   = 0;
   int failures = 0;

   spi_flash_reader dut (
      .clk(clk), .resetn(resetn), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
      .byte_ready_i(byte_ready_i), .cpu_d_i(cpu_d_i), .cpu_wr_i(cpu_wr_i),
      .cpu_rd_i(cpu_rd_i), .cpu_ad_i(cpu_ad_i), .cpu_d_o(cpu_d_o),
      .cpu_blocked_o(cpu_blocked_o), .spi_d_o(spi_d_o), .spi_d_i(spi_d_i),
      .spi_wr_o(spi_wr_o), .spi_rd_o(spi_rd_o), .spi_ad_o(spi_ad_o)
   );

   always #5 clk = ~clk;

   // SPI core model
   logic [2:0] core_busy;
   logic       cs_q;
   logic [7:0] rx_last;
   logic [7:0] dlog[$];
   logic [7:0] clog[$];
   logic [7:0] blog[$];
   int wr_cnt = 0, miso_base = 0, done_cnt = 0, strobe_cnt = 0;

   function automatic logic [7:0] miso_of(input int k);
      if (k == 4) return 8'hA5;
      if (k == 5) return 8'h5A;
      return 8'h3C;
   endfunction

   assign spi_d_i = spi_ad_o ? rx_last : {core_busy != 3'd0, 6'b0, cs_q};

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         core_busy <= 3'd0;
         cs_q      <= 1'b0;
         rx_last   <= 8'h00;
      end else begin
         if (core_busy != 3'd0) core_busy <= core_busy - 3'd1;
         if (spi_wr_o || spi_rd_o) strobe_cnt = strobe_cnt + 1;
         if (spi_wr_o && !spi_ad_o) begin
            clog.push_back(spi_d_o);
            cs_q <= spi_d_o[0];
         end
         if (spi_wr_o && spi_ad_o) begin
            dlog.push_back(spi_d_o);
            core_busy <= 3'd3;
            rx_last   <= miso_of(wr_cnt - miso_base);
            wr_cnt = wr_cnt + 1;
         end
         if (byte_valid_o && byte_ready_i) blog.push_back(byte_o);
         if (done_o) done_cnt = done_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int base);
      int n = 0;
      while (done_cnt == base && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, done_cnt - base, 1);
   endtask

   task automatic start_txn(input logic [23:0] a, input logic [15:0] l);
      @(negedge clk);
      miso_base = wr_cnt;
      start_i = 1'b1;
      addr_i  = a;
      len_i   = l;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   initial begin
      logic [7:0] exp1 [6] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};
      logic [7:0] exp3 [5] = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00};
      int db, cb, bb, dn, sb, bad, n;

      resetn = 1'b0; start_i = 1'b0; addr_i = '0; len_i = '0; byte_ready_i = 1'b0;
      cpu_d_i = '0; cpu_wr_i = 1'b0; cpu_rd_i = 1'b0; cpu_ad_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_valid", byte_valid_o, 0);
      check("rst_byte", byte_o, 8'h00);
      check("rst_blocked", cpu_blocked_o, 0);
      check("rst_spi_wr", spi_wr_o, 0);
      resetn = 1'b1;

      // idle CPU pass-through
      @(negedge clk);
      cpu_wr_i = 1'b1; cpu_ad_i = 1'b0; cpu_d_i = 8'h01;
      #1;
      check("idle_wr_ctrl", {spi_wr_o, spi_ad_o, spi_d_o}, {1'b1, 1'b0, 8'h01});
      check("idle_busy", busy_o, 0);
      @(negedge clk);
      cpu_ad_i = 1'b1; cpu_d_i = 8'h9F;
      #1;
      check("idle_wr_data", {spi_wr_o, spi_ad_o, spi_d_o}, {1'b1, 1'b1, 8'h9F});
      @(negedge clk);
      cpu_wr_i = 1'b0; cpu_rd_i = 1'b1; cpu_ad_i = 1'b0;
      #1;
      check("idle_rd_ctrl", cpu_d_o, 8'h81);
      @(negedge clk);
      cpu_rd_i = 1'b0; cpu_wr_i = 1'b1; cpu_d_i = 8'h00;
      @(negedge clk);
      cpu_wr_i = 1'b0;
      repeat (5) @(negedge clk);

      // two-byte read, consumer always ready
      byte_ready_i = 1'b1;
      db = dlog.size(); cb = clog.size(); bb = blog.size(); dn = done_cnt;
      start_txn(24'h012345, 16'd2);
      check("t1_busy_rise", busy_o, 1);
      wait_done("t1_done", dn);
      repeat (3) @(negedge clk);
      check("t1_ndata", dlog.size() - db, 6);
      for (int i = 0; i < 6; i++)
         if (db + i < dlog.size()) check($sformatf("t1_data%0d", i), dlog[db+i], exp1[i]);
      check("t1_nctrl", clog.size() - cb, 2);
      if (clog.size() >= cb + 2) begin
         check("t1_sel", clog[cb], 8'h01);
         check("t1_desel", clog[cb+1], 8'h00);
      end
      check("t1_nbytes", blog.size() - bb, 2);
      if (blog.size() >= bb + 2) begin
         check("t1_byte0", blog[bb], 8'hA5);
         check("t1_byte1", blog[bb+1], 8'h5A);
      end
      check("t1_one_done", done_cnt - dn, 1);

      // consumer stalls 20 cycles
      byte_ready_i = 1'b0;
      cb = clog.size(); dn = done_cnt;
      start_txn(24'h000010, 16'd1);
      n = 0;
      while (!byte_valid_o && n < 200) begin @(negedge clk); n++; end
      check("t2_valid_seen", byte_valid_o, 1);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!byte_valid_o || byte_o !== 8'hA5 || clog.size() != cb + 1) bad++;
      end
      check("t2_stall_stable", bad, 0);
      byte_ready_i = 1'b1;
      wait_done("t2_done", dn);
      check("t2_desel_after", clog.size() - cb, 2);

      // CPU access and restart while busy
      db = dlog.size(); bb = blog.size(); dn = done_cnt;
      start_txn(24'hABCDEF, 16'd1);
      repeat (3) @(negedge clk);
      cpu_wr_i = 1'b1; cpu_ad_i = 1'b1; cpu_d_i = 8'h9F;
      start_i = 1'b1; len_i = 16'd5; addr_i = 24'h111111;
      #1;
      check("t3_cpu_rd_ff", cpu_d_o, 8'hFF);
      @(negedge clk);
      cpu_wr_i = 1'b0; start_i = 1'b0;
      wait_done("t3_done", dn);
      check("t3_blocked", cpu_blocked_o, 1);
      check("t3_ndata", dlog.size() - db, 5);
      for (int i = 0; i < 5; i++)
         if (db + i < dlog.size()) check($sformatf("t3_data%0d", i), dlog[db+i], exp3[i]);
      check("t3_nbytes", blog.size() - bb, 1);
      cpu_rd_i = 1'b1; cpu_ad_i = 1'b0;
      #1;
      check("t3_ctrl_rd", cpu_d_o, 8'h00);
      @(negedge clk);
      cpu_rd_i = 1'b0;
      check("t3_blocked_clr", cpu_blocked_o, 0);

      // zero-length start
      sb = strobe_cnt; dn = done_cnt;
      @(negedge clk);
      start_i = 1'b1; len_i = 16'd0;
      @(negedge clk);
      start_i = 1'b0;
      check("t5_done_now", done_o, 1);
      check("t5_busy", busy_o, 0);
      @(negedge clk);
      check("t5_done_once", done_o, 0);
      check("t5_no_strobes", strobe_cnt - sb, 0);

      // reset during POLL
      start_txn(24'h000000, 16'd2);
      n = 0;
      while (!(spi_rd_o && !spi_ad_o) && n < 100) begin @(negedge clk); n++; end
      check("t6_in_poll", {spi_rd_o, spi_ad_o}, 2'b10);
      cb = clog.size();
      resetn = 1'b0;
      #1;
      check("t6_busy", busy_o, 0);
      check("t6_strobes", {spi_wr_o, spi_rd_o, done_o, byte_valid_o}, 4'b0000);
      repeat (2) @(negedge clk);
      check("t6_no_desel", clog.size() - cb, 0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_idle", busy_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
